// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

   localparam int DEFAULT_LINES = 64;
   localparam int OFFSET_W      = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL,
      DONE
   } state_t;

   function automatic int idx_width(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_width(input int addr_w, input int lines);
      return addr_w - idx_width(lines) - OFFSET_W;
   endfunction

   function automatic int offset_width();
      return OFFSET_W;
   endfunction

   // Lane 0 is bits [7:0]; the selected byte is sign-extended.
   function automatic logic [31:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] data);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[7:0]   = data;
         2'd1:    w[15:8]  = data;
         2'd2:    w[23:16] = data;
         default: w[31:24] = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the data cache: valid/dirty/tag/data per line, one
// combinational read port and one write port; valid/dirty clear on reset.
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int LINES = DEFAULT_LINES,
   parameter int TAG_W = 24,
   parameter int IDX_W = idx_width(LINES)
)
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic             rd_dirty,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data,
   input  logic             wr_dirty
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   // Tag/data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (rst_b && wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller (one word per line).
// Define DCACHE_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int LINES  = DEFAULT_LINES,
   parameter int ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic              req_is_word,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic [31:0]       rdata,
   output logic              resp_valid,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IDX_W = idx_width(LINES);
   localparam int TAG_W = tag_width(ADDR_W, LINES);

   state_t state, next_state;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       lane;

   logic             line_valid;
   logic             line_dirty;
   logic [TAG_W-1:0] line_tag;
   logic [31:0]      line_data;
   logic             hit;

   logic             wr_en;
   logic             wr_dirty;
   logic [31:0]      wr_data;

   assign idx  = req_addr[IDX_W+1:2];
   assign tag  = req_addr[ADDR_W-1:IDX_W+2];
   assign lane = req_addr[1:0];
   assign hit  = line_valid && (line_tag == tag);

   dcache_line_array #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .IDX_W (IDX_W)
   ) u_lines (
      .clk      (clk),
      .rst_b    (rst_b),
      .rd_idx   (idx),
      .rd_valid (line_valid),
      .rd_dirty (line_dirty),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (wr_en),
      .wr_idx   (idx),
      .wr_tag   (tag),
      .wr_data  (wr_data),
      .wr_dirty (wr_dirty)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         rdata <= '0;
      end else if (state == LOOKUP && hit && !req_we) begin
         rdata <= req_is_word ? line_data : byte_extract(line_data, lane);
      end
   end

   // The array is written on a store hit and when refill data arrives.
   always_comb begin
      next_state = state;
      wr_en      = 1'b0;
      wr_dirty   = 1'b0;
      wr_data    = mem_rdata;
      case (state)
         IDLE: begin
            if (req_valid) begin
               next_state = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               next_state = DONE;
               if (req_we) begin
                  wr_en    = 1'b1;
                  wr_dirty = 1'b1;
                  wr_data  = req_is_word ? req_wdata
                                         : byte_merge(line_data, lane, req_wdata[7:0]);
               end
            end else if (line_valid && line_dirty) begin
               next_state = WB;
            end else begin
               next_state = FILL;
            end
         end
         WB: begin
            if (mem_ack) begin
               next_state = FILL;
            end
         end
         FILL: begin
            if (mem_ack) begin
               wr_en      = 1'b1;
               wr_dirty   = 1'b0;
               wr_data    = mem_rdata;
               next_state = LOOKUP;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Memory-side outputs follow the state, so they hold until the ack moves it on.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {line_tag, idx, 2'b00};
            mem_wdata = line_data;
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag, idx, 2'b00};
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   assign resp_valid = (state == DONE);
   assign stall      = req_valid && (state != DONE);

`ifdef DCACHE_STATS_EN
   logic        first_lookup;
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // Only the lookup entered from IDLE counts; the re-lookup after a refill does not.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         first_lookup <= 1'b0;
         hit_q        <= '0;
         miss_q       <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            first_lookup <= 1'b1;
         end else if (state == LOOKUP) begin
            first_lookup <= 1'b0;
         end
         if (state == LOOKUP && first_lookup) begin
            if (hit) begin
               if (hit_q != 32'hFFFF_FFFF) begin
                  hit_q <= hit_q + 32'd1;
               end
            end else if (miss_q != 32'hFFFF_FFFF) begin
               miss_q <= miss_q + 32'd1;
            end
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses, a 3-cycle-ack memory model,
// and a monitor that checks responses and memory transactions against queued expectations.
module tb_dcache_controller;

   typedef struct {
      logic        chk;
      logic [31:0] data;
   } resp_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   logic        clk;
   logic        rst_b;
   logic        req_valid;
   logic        req_we;
   logic        req_is_word;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        resp_valid;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   resp_exp_t resp_q[$];
   mem_exp_t  mem_q[$];

   logic [31:0] refill_data;
   int          stray_req  = 0;
   int          stray_done = 0;

   dcache_controller #(
      .LINES  (64),
      .ADDR_W (32)
   ) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_is_word (req_is_word),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rdata       (rdata),
      .resp_valid  (resp_valid),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic expectMem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      mem_q.push_back('{we, addr, wdata});
   endtask

   // Issue one access, hold it while stalled, and check completion latency.
   task automatic applyStimulus(input logic we, input logic is_word, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic chk,
                                input logic [31:0] exp_data, input int exp_lat);
      int cycles;
      resp_q.push_back('{chk, exp_data});
      @(negedge clk);
      req_we      = we;
      req_is_word = is_word;
      req_addr    = addr;
      req_wdata   = wdata;
      req_valid   = 1'b1;
      #1;
      checkOutput("stall_on_request", {31'd0, stall}, 32'd1);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!resp_valid && cycles < 200);
      if (!resp_valid) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL access_timeout: addr 0x%08h got no resp_valid, required one within 200 cycles", addr);
      end else begin
         checkOutput("latency", cycles, exp_lat);
         checkOutput("stall_in_done", {31'd0, stall}, 32'd0);
      end
      req_valid = 1'b0;
   endtask

   // Memory model: acks three cycles after a request appears; also serves stray ack pulses.
   initial begin : mem_model
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            mem_rdata = 32'h5555_5555;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            stray_done++;
         end else if (mem_req) begin
            repeat (2) @(negedge clk);
            if (mem_req) begin
               mem_rdata = mem_we ? 32'h0 : refill_data;
               mem_ack   = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes an access or opens a transfer.
   initial begin : monitor
      logic        txn_open;
      logic [31:0] open_addr;
      resp_exp_t   r;
      mem_exp_t    m;
      txn_open  = 1'b0;
      open_addr = '0;
      forever begin
         @(negedge clk);
         #1;
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_resp: got resp_valid with rdata 0x%08h, required none", rdata);
            end else begin
               r = resp_q.pop_front();
               if (r.chk) begin
                  checkOutput("rdata", rdata, r.data);
               end
            end
         end
         if (!mem_req) begin
            txn_open = 1'b0;
         end else if (!txn_open) begin
            txn_open  = 1'b1;
            open_addr = mem_addr;
            if (mem_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_mem_req: got mem_req we=%0d addr 0x%08h, required none",
                        mem_we, mem_addr);
            end else begin
               m = mem_q.pop_front();
               checkOutput("mem_we", {31'd0, mem_we}, {31'd0, m.we});
               checkOutput("mem_addr", mem_addr, m.addr);
               if (m.we) begin
                  checkOutput("mem_wdata", mem_wdata, m.wdata);
               end
            end
         end
         if (mem_req && txn_open && mem_ack) begin
            checkOutput("mem_addr_stable", mem_addr, open_addr);
            txn_open = 1'b0;
         end
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_rdata"}, rdata, 32'h0);
      checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      checkOutput({tag, "_hit_count"}, hit_count, 32'h0);
      checkOutput({tag, "_miss_count"}, miss_count, 32'h0);
   endtask

   initial begin : stimulus
      int   cycles;
      logic [31:0] exp_stat;
      rst_b       = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_is_word = 1'b1;
      req_addr    = '0;
      req_wdata   = '0;
      refill_data = '0;
      repeat (3) @(negedge clk);
      #1;
      checkResetState("reset");
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;

      // Cold miss then hit on the same word.
      refill_data = 32'hDEAD_BEEF;
      expectMem(1'b0, 32'h100, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 6);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 2);
`ifdef DCACHE_STATS_EN
      exp_stat = 32'd1;
`else
      exp_stat = 32'd0;
`endif
      @(negedge clk);
      checkOutput("hit_count", hit_count, exp_stat);
      checkOutput("miss_count", miss_count, exp_stat);

      // Store hit dirties the line; a conflicting load writes it back first.
      applyStimulus(1'b1, 1'b1, 32'h100, 32'h1234_5678, 1'b0, 32'h0, 2);
      refill_data = 32'hCAFE_F00D;
      expectMem(1'b1, 32'h100, 32'h1234_5678);
      expectMem(1'b0, 32'h200, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 32'hCAFE_F00D, 10);

      // Clean victim: refill 0x100 without writeback, then byte accesses.
      refill_data = 32'h1234_5678;
      expectMem(1'b0, 32'h100, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h1234_5678, 6);
      applyStimulus(1'b1, 1'b0, 32'h101, 32'hFFFF_FF80, 1'b0, 32'h0, 2);
      applyStimulus(1'b0, 1'b0, 32'h101, 32'h0, 1'b1, 32'hFFFF_FF80, 2);
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_0078, 2);
      applyStimulus(1'b0, 1'b0, 32'h103, 32'h0, 1'b1, 32'h0000_0012, 2);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h1234_8078, 2);

      // Reset in the middle of a refill aborts the transfer.
      refill_data = 32'h7777_7777;
      expectMem(1'b0, 32'h104, 32'h0);
      @(negedge clk);
      req_we      = 1'b0;
      req_is_word = 1'b1;
      req_addr    = 32'h104;
      req_valid   = 1'b1;
      cycles      = 0;
      while (!mem_req && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("fill_started", {31'd0, mem_req}, 32'd1);
      rst_b = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("abort_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("abort_stall_high", {31'd0, stall}, 32'd1);
      req_valid = 1'b0;
      #1;
      checkOutput("abort_stall_low", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      checkResetState("midreset");
      @(negedge clk);
      rst_b = 1'b1;

      // Dirty data was discarded by reset: 0x100 refills with no writeback.
      refill_data = 32'h0BAD_F00D;
      expectMem(1'b0, 32'h100, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h0BAD_F00D, 6);

      // A stray ack in IDLE must not move the FSM or write a line.
      @(negedge clk);
      req_addr = 32'h104;
      stray_req++;
      cycles = 0;
      while (stray_done != stray_req && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      @(negedge clk);
      #1;
      checkOutput("stray_ack_stall", {31'd0, stall}, 32'd0);
      checkOutput("stray_ack_resp", {31'd0, resp_valid}, 32'd0);
      checkOutput("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h0BAD_F00D, 2);
      refill_data = 32'h4444_4444;
      expectMem(1'b0, 32'h104, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h104, 32'h0, 1'b1, 32'h4444_4444, 6);

      repeat (3) @(negedge clk);
      checkOutput("resp_queue_drained", resp_q.size(), 32'd0);
      checkOutput("mem_queue_drained", mem_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
